// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, 8 data bits LSB first, 1 stop bit, optional even parity.
//   i_clk        system clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset (assert async, release sync)
//   i_uart_rx    asynchronous serial line, idle high
//   o_data       last good byte received
//   o_valid      one-cycle pulse, o_data holds a new good byte
//   o_busy       high while a frame is in progress (any state but IDLE)
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_parity_err one-cycle pulse, parity mismatch (constant 0 without UART_RX_PARITY_EN)
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] fill_q, fill_d;
  logic armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;
  logic rx_s;
  logic last;
`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif
  assign rx_s = sync_q[1];
  assign last = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], i_uart_rx};
    // fill_q[1] marks that the synchronizer holds real line samples rather than reset values;
    // only then may a high rx_s arm start detection, so a line low at reset release is ignored.
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & rx_s);
    cnt_d   = (state_q == IDLE || state_q == WAIT_IDLE) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = (armed_q && !rx_s) ? START : IDLE;
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
          state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (last) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : WAIT_IDLE;
          ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = rx_s && par_bad_q;
          valid_d = rx_s && !par_bad_q;
          data_d  = (rx_s && !par_bad_q) ? shift_q : data_q;
`else
          valid_d = rx_s;
          data_d  = rx_s ? shift_q : data_q;
`endif
        end
      end
      WAIT_IDLE: state_d = rx_s ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = state_q != IDLE;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 i_clk  input  1  system clock; all state on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_uart_rx  input  1  asynchronous serial line; idle high.
REQ-005 o_data  output  8  last received byte.
REQ-006 o_valid  output  1  one-cycle pulse; o_data holds a new good byte.
REQ-007 o_busy  output  1  high while a frame is being received.
REQ-008 o_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 o_parity_err  output  1  one-cycle pulse; parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-010 i_uart_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-030), and 1 stop bit (1).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-013 IDLE: rx_s==0 SHALL enter START, load the bit counter with 0, and assert o_busy from the next cycle.
REQ-014 START: at count CLKS_PER_BIT/2-1 (integer division), rx_s SHALL be sampled; 0 enters DATA with the counter reset; 1 is a glitch and returns to IDLE with no output pulse.
REQ-015 DATA: every CLKS_PER_BIT cycles after the start mid-point, rx_s SHALL be shifted into bit index 0..7; after bit 7 the FSM enters PARITY (macro) or STOP.
REQ-016 STOP: rx_s SHALL be sampled one bit period after the last data or parity sample.
REQ-017 Stop==1 with no parity error: o_data SHALL update and o_valid SHALL pulse high for exactly the next cycle; the FSM returns to IDLE.
REQ-018 Stop==0: o_frame_err SHALL pulse for one cycle; o_data and o_valid SHALL be left unchanged; the FSM enters WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL remain until rx_s==1, then return to IDLE; a break condition (line held low) therefore never produces repeated frames.
REQ-020 o_valid, o_frame_err and o_parity_err SHALL be mutually exclusive.
REQ-021 o_busy SHALL be high in every state except IDLE.
REQ-022 The bit counter SHALL be sized with $clog2(CLKS_PER_BIT) and SHALL never wrap within a bit period.
REQ-023 Latency: o_valid SHALL rise 1 cycle after the stop-bit mid-sample, i.e. roughly 9.5 bit times plus 3 synchronizer/register cycles from the start edge (10.5 bit times with parity).
REQ-024 A falling edge on the cycle the FSM returns to IDLE SHALL be detected no later than the following cycle, so back-to-back frames are received without loss.
REQ-025 No receive FIFO is provided; o_data SHALL be overwritten by the next good frame, and the consumer must capture it on o_valid.

Reset
REQ-026 While i_rst_n==0, the FSM SHALL be in IDLE, with o_data=8'h00, o_valid=0, o_busy=0, o_frame_err=0, o_parity_err=0, counters=0, and both synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no pulse on any output.
REQ-028 After reset release, a line already low SHALL be treated as a start edge only after rx_s has been seen high at least once; until then the FSM stays in WAIT_IDLE-equivalent behaviour.
REQ-029 Reset release SHALL be synchronous to i_clk; assertion SHALL be asynchronous.

Configuration
REQ-030 When UART_RX_PARITY_EN is defined, one even-parity bit SHALL follow the data bits and be sampled in PARITY; a mismatch SHALL pulse o_parity_err (stop==1) in place of o_valid, with o_data unchanged; a bad stop bit still takes priority and gives o_frame_err.
REQ-031 When UART_RX_PARITY_EN is undefined, the PARITY state and its logic SHALL NOT be present, frames SHALL be 10 bits, and o_parity_err SHALL be constant 0.

Verification (CLKS_PER_BIT=4, driven from the existing uart_tx model where possible)
REQ-032 Frame 0x55 sent after reset -> exactly one o_valid pulse with o_data=8'h55, and o_busy high for the whole frame.
REQ-033 Back-to-back frames 0xA5, 0x3C, 0xFF with no idle gap -> three o_valid pulses in order with matching o_data and no errors.
REQ-034 A 1-cycle low glitch on an idle line -> return to IDLE, with no o_valid and no o_frame_err.
REQ-035 Frame 0x81 with the stop bit forced 0, line then held low for 40 cycles -> a single o_frame_err pulse, o_data still holding its previous value, and the next good frame 0x12 received correctly.
REQ-036 i_rst_n pulsed low during bit 4 of frame 0xC3 -> no output pulses and outputs at reset values; a following frame 0x0F -> o_data=8'h0F.
REQ-037 With UART_RX_PARITY_EN defined, 0x07 sent with wrong parity -> one o_parity_err pulse and no o_valid; 0x07 sent with correct parity -> o_valid with o_data=8'h07.
